int_ctrl: RTL
=============

INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter VEC_BASE, default 10'd1008, is the program address of the source-0 interrupt vector.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 irq  input  4  interrupt request lines, synchronous to clk, rising-edge triggered.
REQ-005 mask_we  input  1  mask write strobe.
REQ-006 mask_in  input  4  new mask value; bit=1 enables that source.
REQ-007 int_ack  input  1  CPU accepts the offered interrupt; it has saved the PC and loaded int_vec.
REQ-008 int_done  input  1  CPU executed return-from-interrupt.
REQ-009 int_req  output  1  interrupt offered to the CPU.
REQ-010 int_vec  output  10  vector address of the offered or in-service source.
REQ-011 int_id  output  2  index of the offered or in-service source.
REQ-012 pending  output  4  latched, not-yet-acknowledged requests.
REQ-013 mask_out  output  4  current mask register.

Function
REQ-014 Registered copy irq_d; rise[i] = irq[i] & ~irq_d[i]; a rise sets pending[i] at the same edge, regardless of mask.
REQ-015 A level held high does not re-set pending; a new rise is required.
REQ-016 mask_we=1 loads mask_in into the mask at the next edge; the mask affects arbitration only, never pending.
REQ-017 eligible = pending & mask.
REQ-018 FSM states: IDLE, REQ, SERVICE; int_req = (state==REQ), decoded from the state register.
REQ-019 IDLE: if eligible != 0, latch the winner into int_id and go to REQ; otherwise stay.
REQ-020 REQ: int_ack=1 clears pending[int_id] and goes to SERVICE.
REQ-021 REQ: if mask[int_id]==0 and int_ack==0, withdraw to IDLE without clearing pending; int_ack wins when both occur in the same cycle.
REQ-022 SERVICE: int_done=1 goes to IDLE; new rises still set pending; no nesting.
REQ-023 int_ack outside REQ and int_done outside SERVICE are ignored.
REQ-024 A rise on source int_id in the same cycle as its ack-clear leaves pending[int_id]=1 (set wins).
REQ-025 int_vec = VEC_BASE + 4*int_id, 10-bit, wraps modulo 1024; stable throughout REQ and SERVICE.
REQ-026 Default arbitration is fixed priority: lowest index wins (irq[0] highest).
REQ-027 Latency: rise sampled at edge k, pending at k, REQ entered at k+1; int_req high 2 cycles after irq rises when IDLE and unmasked.
REQ-028 After int_done at edge d, the next int_req rises after edge d+1 at the earliest.

Reset
REQ-029 reset low asynchronously sets state=IDLE, pending=0, mask=0, irq_d=0, int_id=0 (int_vec=VEC_BASE), int_req=0, and last_id=3.
REQ-030 Reset asserted in REQ or SERVICE discards the in-flight interrupt; nothing is retained after reset deassertion.

Configuration
REQ-031 Macro INT_ROUND_ROBIN_EN defined: arbitration is rotating priority, searching from last_id+1 upward modulo 4; last_id is updated to int_id on int_ack.
REQ-032 Macro absent: fixed priority per REQ-026; last_id is not implemented.

Verification
REQ-033 Reset, then mask_we with mask_in=4'b1111, irq=4'b0100 pulse -> pending=4'b0100; int_req=1 two cycles after rise, int_id=2, int_vec=1016.
REQ-034 Mask=4'b1111, irq[3] and irq[1] rise together -> int_id=1; ack then done -> int_id=3 offered next, int_vec=1020; pending ends 0.
REQ-035 Mask=4'b0000, irq[0] rises -> pending=4'b0001, int_req stays 0; then mask_in=4'b0001 written -> int_req=1 two cycles later.
REQ-036 In REQ for id 2, write mask=4'b1011 without ack -> int_req=0 next cycle, pending[2] still 1; on the same cycle ack+mask clear -> SERVICE entered, pending[2]=0.
REQ-037 In SERVICE for id 0, irq[0] re-rises -> pending[0]=1, int_req stays 0 until int_done, then reasserts; reset mid-SERVICE -> all outputs at reset values immediately.
REQ-038 INT_ROUND_ROBIN_EN defined, mask=4'b1111, irq[0] and irq[1] held pending with repeated rises -> service order 0,1,0,1; without the macro -> 0,0,0.

Source files
------------

// File: rtl/int_ctrl.sv
// int_ctrl: four-source edge-triggered interrupt controller.
// Latches rising edges on irq into pending, arbitrates among unmasked
// pending sources, offers one to the CPU (REQ) and tracks it until the
// return-from-interrupt (SERVICE). No nesting.
// Optional feature macro: INT_ROUND_ROBIN_EN selects rotating priority
// (search from the last acknowledged source + 1); otherwise fixed priority
// with irq[0] highest.
module int_ctrl #(
  parameter logic [9:0] VEC_BASE = 10'd1008
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] irq,
  input  logic       mask_we,
  input  logic [3:0] mask_in,
  input  logic       int_ack,
  input  logic       int_done,
  output logic       int_req,
  output logic [9:0] int_vec,
  output logic [1:0] int_id,
  output logic [3:0] pending,
  output logic [3:0] mask_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] irq_d;
  logic [3:0] rise;
  logic [3:0] eligible;
  logic [3:0] clr;
  logic [1:0] winner;
  logic [1:0] id_nxt;

  assign rise     = irq & ~irq_d;
  assign eligible = pending & mask_out;

`ifdef INT_ROUND_ROBIN_EN
  logic [1:0] last_id;
  logic       found;
  logic [1:0] idx;

  // Rotating priority: first eligible source after the last acknowledged one.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = last_id + 2'(k);
      if (!found && eligible[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // Remember the source most recently accepted by the CPU.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_id <= 2'd3;
    end else if (state == REQ && int_ack) begin
      last_id <= int_id;
    end
  end
`else
  // Fixed priority: lowest index wins; scan downward so the lowest hit sticks.
  always_comb begin
    winner = '0;
    for (int unsigned i = 4; i > 0; i--) begin
      if (eligible[i-1]) begin
        winner = 2'(i - 1);
      end
    end
  end
`endif

  // Next-state, id latch and pending-clear decode.
  always_comb begin
    state_nxt = state;
    id_nxt    = int_id;
    clr       = '0;
    case (state)
      IDLE: begin
        if (|eligible) begin
          state_nxt = REQ;
          id_nxt    = winner;
        end
      end
      REQ: begin
        // Acknowledge takes precedence over a mask-driven withdrawal.
        if (int_ack) begin
          state_nxt = SERVICE;
          clr       = 4'b0001 << int_id;
        end else if (!mask_out[int_id]) begin
          state_nxt = IDLE;
        end
      end
      SERVICE: begin
        if (int_done) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, id, edge detector, mask and pending registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      int_id   <= '0;
      irq_d    <= '0;
      mask_out <= '0;
      pending  <= '0;
    end else begin
      state   <= state_nxt;
      int_id  <= id_nxt;
      irq_d   <= irq;
      if (mask_we) begin
        mask_out <= mask_in;
      end
      // A new rise on the source being acknowledged wins over the clear.
      pending <= (pending & ~clr) | rise;
    end
  end

  assign int_req = (state == REQ);
  assign int_vec = VEC_BASE + {6'd0, int_id, 2'b00};

endmodule
